// File: rtl/frame_config_loader.sv
// Configuration loader: turns a 32-bit bitstream word stream into FrameData rows
// and a single-cycle, one-hot FrameStrobe pulse per addressed frame.
module frame_config_loader #(
    parameter int FrameBitsPerRow = 32,
    parameter int MaxFramesPerCol = 20,
    parameter int NumRows         = 4,
    parameter int NumCols         = 3
) (
    input  logic                                 CLK,
    input  logic                                 resetn,
    input  logic [31:0]                          s_data,
    input  logic                                 s_valid,
    output logic                                 s_ready,
    output logic [NumRows*FrameBitsPerRow-1:0]   FrameData,
    output logic [NumCols*MaxFramesPerCol-1:0]   FrameStrobe,
    output logic                                 active,
    output logic                                 error,
    output logic [15:0]                          frame_count
);

    localparam int DataW = NumRows * FrameBitsPerRow;
    localparam int StrbW = NumCols * MaxFramesPerCol;
    localparam int RowW  = (NumRows > 1) ? $clog2(NumRows) : 1;
    localparam int IdxW  = (StrbW > 1) ? $clog2(StrbW) : 1;

    localparam logic [31:0] SYNC   = 32'hFAB0_FAB1;
    localparam logic [31:0] DESYNC = 32'hFAB0_FAB0;

    typedef enum logic [2:0] {
        S_IDLE,
        S_HEADER,
        S_DATA,
        S_STROBE,
        S_HOLD
    } state_e;

    state_e            state_q, state_d;
    logic [DataW-1:0]  data_q, data_d;
    logic [StrbW-1:0]  strobe_q, strobe_d;
    logic              active_q, active_d;
    logic              error_q, error_d;
    logic [15:0]       count_q, count_d;
    logic              ready_q, ready_d;
    logic [RowW-1:0]   row_q, row_d;
    logic [IdxW-1:0]   idx_q, idx_d;
    logic              valid_addr_q, valid_addr_d;

    logic              accept;
    logic [15:0]       hdr_col;
    logic [15:0]       hdr_frame;
    logic              hdr_ok;
    logic [IdxW-1:0]   hdr_idx;

    assign accept    = s_valid && ready_q;
    assign hdr_col   = s_data[31:16];
    assign hdr_frame = s_data[15:0];
    assign hdr_ok    = (hdr_col < 16'(NumCols)) && (hdr_frame < 16'(MaxFramesPerCol));
    // Only meaningful when hdr_ok, so the narrowing casts never lose a set bit.
    assign hdr_idx   = IdxW'(hdr_col) * IdxW'(MaxFramesPerCol) + IdxW'(hdr_frame);

    // NOTE: every _d gets a default before the case so no path leaves it unassigned (no latches).
    always_comb begin
        state_d      = state_q;
        data_d       = data_q;
        strobe_d     = '0;
        active_d     = active_q;
        error_d      = error_q;
        count_d      = count_q;
        row_d        = row_q;
        idx_d        = idx_q;
        valid_addr_d = valid_addr_q;

        case (state_q)
            S_IDLE: begin
                if (accept && s_data == SYNC) begin
                    state_d  = S_HEADER;
                    active_d = 1'b1;
                    error_d  = 1'b0;
                    count_d  = '0;
                end
            end
            S_HEADER: begin
                if (accept) begin
                    if (s_data == DESYNC) begin
                        state_d  = S_IDLE;
                        active_d = 1'b0;
                    end else if (s_data != SYNC) begin
                        valid_addr_d = hdr_ok;
                        if (hdr_ok) idx_d = hdr_idx;
                        else        error_d = 1'b1;
                        row_d   = '0;
                        state_d = S_DATA;
                    end
                end
            end
            S_DATA: begin
                if (accept) begin
                    if (valid_addr_q)
                        data_d[row_q*FrameBitsPerRow +: FrameBitsPerRow] = s_data;
                    if (row_q == RowW'(NumRows - 1)) begin
                        if (valid_addr_q) begin
                            state_d  = S_STROBE;
                            strobe_d = StrbW'(1) << idx_q;
                            count_d  = count_q + 16'd1;
                        end else begin
                            state_d = S_HEADER;
                        end
                    end else begin
                        row_d = row_q + RowW'(1);
                    end
                end
            end
            S_STROBE: state_d = S_HOLD;
            S_HOLD:   state_d = S_HEADER;
            default:  state_d = S_IDLE;
        endcase

        ready_d = (state_d == S_IDLE) || (state_d == S_HEADER) || (state_d == S_DATA);
    end

    // NOTE: state registers use non-blocking assignments only; all outputs clear asynchronously.
    always_ff @(posedge CLK or negedge resetn) begin
        if (!resetn) begin
            state_q      <= S_IDLE;
            data_q       <= '0;
            strobe_q     <= '0;
            active_q     <= 1'b0;
            error_q      <= 1'b0;
            count_q      <= '0;
            ready_q      <= 1'b0;
            row_q        <= '0;
            idx_q        <= '0;
            valid_addr_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            data_q       <= data_d;
            strobe_q     <= strobe_d;
            active_q     <= active_d;
            error_q      <= error_d;
            count_q      <= count_d;
            ready_q      <= ready_d;
            row_q        <= row_d;
            idx_q        <= idx_d;
            valid_addr_q <= valid_addr_d;
        end
    end

    assign s_ready     = ready_q;
    assign FrameData   = data_q;
    assign FrameStrobe = strobe_q;
    assign active      = active_q;
    assign error       = error_q;
    assign frame_count = count_q;

endmodule
